// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter, 11-bit deframer, show-ahead scan-code FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles mid-frame.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                          clk,
   input  logic                          clrn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    data,
   output logic                          ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          parity_err,
   output logic                          frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic [3:0]    flt_cnt;
   logic          fclk, fclk_q;
   logic          smp;
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          par_ok;
   logic          wr_req, pe_set, fe_set, ovf_set;
   logic          to_fire;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          full, empty, do_rd, do_wr;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // fclk follows clk_s2 only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         flt_cnt <= '0;
         fclk    <= 1'b1;
         fclk_q  <= 1'b1;
      end else begin
         fclk_q <= fclk;
         if (clk_s2 == fclk) begin
            flt_cnt <= '0;
         end else if (flt_cnt == 4'(FILTER_LEN - 1)) begin
            fclk    <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 4'd1;
         end
      end
   end

   assign smp = fclk_q & ~fclk;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TW-1:0] to_cnt;

   assign to_fire = (state != IDLE) && !smp && (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         to_cnt <= '0;
      end else if (state == IDLE || smp || to_fire) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TW'(1);
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign to_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (to_fire) begin
         state <= IDLE;
      end else if (smp) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               shreg   <= {dat_s2, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
               par_bit <= dat_s2;
               state   <= STOP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stop-bit decisions are combinational so the FIFO is written on the edge that sees smp
   always_comb begin
      par_ok = ^{shreg, par_bit};
      wr_req = smp && (state == STOP) && dat_s2 && par_ok;
      pe_set = smp && (state == STOP) && dat_s2 && !par_ok;
      fe_set = (smp && (((state == IDLE) && dat_s2) || ((state == STOP) && !dat_s2))) || to_fire;
   end

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_req && (!full || do_rd);
   assign ovf_set = wr_req && full && !do_rd;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_wr) wptr <= wptr + AW'(1);
         if (do_rd) rptr <= rptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // A set on the same cycle as clr_err wins
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (pe_set)       parity_err <= 1'b1;
         else if (clr_err) parity_err <= 1'b0;
         if (fe_set)       frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
      end
   end

   assign ready = !empty;
   assign data  = empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed + randomized bench for ps2_rx_fifo against a queue-based model of the received byte stream.
module tb_ps2_rx_fifo;

   logic       clk = 1'b0;
   logic       clrn;
   logic       ps2_clk, ps2_data, rd_en, clr_err;
   logic [7:0] data;
   logic       ready;
   logic [3:0] level;
   logic       overflow, parity_err, frame_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] q[$];
   logic       m_ovf, m_pe, m_fe;

   always #5 clk = ~clk;

   ps2_rx_fifo #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .clr_err(clr_err), .data(data), .ready(ready),
      .level(level), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
   );

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".ready"}, 32'(ready), 32'(q.size() != 0));
      chk({tag, ".level"}, 32'(level), 32'(q.size()));
      chk({tag, ".data"}, 32'(data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".perr"}, 32'(parity_err), 32'(m_pe));
      chk({tag, ".ferr"}, 32'(frame_err), 32'(m_fe));
   endtask

   // One PS/2 bit: data set while clock high, clock low for 20 cycles
   task automatic bit_cell(input logic v, input logic is_stop, input logic pop, input logic lat);
      @(negedge clk) ps2_data = v;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      if (is_stop && (pop || lat)) begin
         repeat (6) @(negedge clk);
         if (lat) chk("lat_before", 32'(ready), 32'h0);
         if (pop) rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
         if (lat) chk("lat_after", 32'(ready), 32'h1);
         repeat (13) @(negedge clk);
      end else begin
         repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input logic pop, input logic lat);
      logic p;
      p = (~^b) ^ par_flip;
      bit_cell(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) bit_cell(b[i], 1'b0, 1'b0, 1'b0);
      bit_cell(p, 1'b0, 1'b0, 1'b0);
      bit_cell(stop, 1'b1, pop, lat);
      if (pop && q.size() != 0) void'(q.pop_front());
      if (!stop)                m_fe = 1'b1;
      else if (!(^{b, p}))      m_pe = 1'b1;
      else if (q.size() >= 8)   m_ovf = 1'b1;
      else                      q.push_back(b);
   endtask

   task automatic pop_one(input string tag);
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      chk_all(tag);
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      m_ovf = 1'b0;
      m_pe  = 1'b0;
      m_fe  = 1'b0;
   endtask

   initial begin
      clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      m_ovf = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("reset");
      clrn = 1'b1;
      repeat (5) @(negedge clk);

      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("rx_1c");
      pop_one("pop_1c");

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("fill9");
      for (int i = 0; i < 8; i++) pop_one("drain9");
      pulse_clr();
      chk_all("clr_ovf");

      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("par_bad");
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_all("stop_bad");
      pulse_clr();
      chk_all("clr_all");

      @(negedge clk) ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      chk_all("glitch");
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("rx_f0");
      pop_one("pop_f0");

      for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("full8");
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_all("full_wr_rd");
      for (int i = 0; i < 8; i++) pop_one("drain_full");

      for (int n = 0; n < 20; n++) begin
         int unsigned kind, npop;
         kind = $urandom_range(0, 9);
         send_frame(8'($urandom), kind == 0, kind != 1, 1'b0, 1'b0);
         chk_all("rand_rx");
         npop = $urandom_range(0, 2);
         for (int k = 0; k < int'(npop); k++) pop_one("rand_pop");
         if ($urandom_range(0, 3) == 0) begin
            pulse_clr();
            chk_all("rand_clr");
         end
      end
      while (q.size() != 0) pop_one("final_drain");

`ifdef PS2_RX_TIMEOUT_EN
      pulse_clr();
      bit_cell(1'b0, 1'b0, 1'b0, 1'b0);
      bit_cell(1'b1, 1'b0, 1'b0, 1'b0);
      bit_cell(1'b0, 1'b0, 1'b0, 1'b0);
      bit_cell(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (50) @(negedge clk);
      chk_all("to_pending");
      repeat (80) @(negedge clk);
      m_fe = 1'b1;
      chk_all("to_fired");
      pulse_clr();
      send_frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("rx_2a");
      pop_one("pop_2a");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
